// File: rtl/mem_arb_pkg.sv
// Shared constants for the two-port RAM arbiter: default widths and the
// 2-bit FSM state encodings used by the RTL and the bench.
package mem_arb_pkg;

  localparam int unsigned default_data_width = 16;
  localparam int unsigned default_addr_width = 8;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t ISSUE = 2'd1;
  localparam state_t WAIT  = 2'd2;
  localparam state_t DONE  = 2'd3;

  // Number of cycles from the sampling IDLE cycle to the ack cycle.
  function automatic int unsigned ack_latency(input logic we);
    return we ? 2 : 3;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side bundle for mem_arbiter: two request/ack channels plus the
// shared read-data and busy indications.
interface mem_arbiter_if #(
  parameter int unsigned data_width = 16,
  parameter int unsigned addr_width = 8
);

  logic                  req0;
  logic                  req1;
  logic                  we0;
  logic                  we1;
  logic [addr_width-1:0] addr0;
  logic [addr_width-1:0] addr1;
  logic [data_width-1:0] wdata0;
  logic [data_width-1:0] wdata1;
  logic                  ack0;
  logic                  ack1;
  logic [data_width-1:0] rdata;
  logic                  busy;

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    input  ack0, ack1, rdata, busy
  );

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
    output ack0, ack1, rdata, busy
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin picker. On a tie the port not granted last wins;
// last_grant resets to 1 so port 0 wins the first tie.
module rr_arb2 (
  input  logic clk,
  input  logic reset,
  input  logic req0,
  input  logic req1,
  input  logic update,
  output logic gnt_id
);

  logic last_grant_q;

  // With no request the value is unused; a lone req1 selects port 1.
  always_comb begin
    if (req0 && req1) begin
      gnt_id = ~last_grant_q;
    end else begin
      gnt_id = req1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b1;
    end else if (update) begin
      last_grant_q <= gnt_id;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto one single-port RAM with 1-cycle read latency.
// All outputs are decoded from registered state; requests are sampled only in IDLE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned data_width = default_data_width,
  parameter int unsigned addr_width = default_addr_width
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_arbiter_if.slave          bus,
  output logic [addr_width-1:0] mem_read_address,
  output logic [addr_width-1:0] mem_write_address,
  output logic                  mem_write,
  output logic [data_width-1:0] mem_din,
  input  logic [data_width-1:0] mem_dout
);

  state_t                state_q;
  state_t                state_d;
  logic                  we_q;
  logic [addr_width-1:0] addr_q;
  logic [data_width-1:0] wdata_q;
  logic                  id_q;
  logic [data_width-1:0] rdata_q;
  logic                  gnt_id;
  logic                  grant;

  assign grant = (state_q == IDLE) && (bus.req0 || bus.req1);

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .reset  (reset),
    .req0   (bus.req0),
    .req1   (bus.req1),
    .update (grant),
    .gnt_id (gnt_id)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = ISSUE;
      ISSUE:   state_d = we_q ? DONE : WAIT;
      WAIT:    state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      id_q    <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (grant) begin
        id_q    <= gnt_id;
        we_q    <= gnt_id ? bus.we1    : bus.we0;
        addr_q  <= gnt_id ? bus.addr1  : bus.addr0;
        wdata_q <= gnt_id ? bus.wdata1 : bus.wdata0;
      end
      // RAM output is valid one cycle after ISSUE presented the address.
      if (state_q == WAIT) begin
        rdata_q <= mem_dout;
      end
    end
  end

  assign mem_read_address  = addr_q;
  assign mem_write_address = addr_q;
  assign mem_din           = wdata_q;
  assign mem_write         = (state_q == ISSUE) && we_q;

  assign bus.ack0  = (state_q == DONE) && !id_q;
  assign bus.ack1  = (state_q == DONE) && id_q;
  assign bus.busy  = (state_q != IDLE);
  assign bus.rdata = rdata_q;

endmodule
